vga_frame_regs: RTL and testbench

//  Upstream stage of the VGA sprite renderer. Captures Avalon-MM register writes into shadow registers.

---
 rtl/vga_frame_regs.sv | 149 ++++++++++++++
 tb/tb_vga_frame_regs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_regs.sv
// Avalon shadow registers with a per-frame commit at the start of vblank, plus animation and BCD score.
// Optional macro VGA_FRAME_IRQ_EN enables a sticky frame interrupt acknowledged at address 15.
module vga_frame_regs #(
    parameter int VACTIVE   = 480,
    parameter int ANIM_DIV  = 6,
    parameter int SCORE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] writedata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [49:0] spr_x,
    output logic [49:0] spr_y,
    output logic [7:0]  score_x,
    output logic [7:0]  score_y,
    output logic [11:0] score_bcd,
    output logic [1:0]  anim_phase,
    output logic        frame_start,
    output logic        frame_irq
);

    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int SW = $clog2(SCORE_DIV + 1);
    localparam logic [49:0] X_RST = {10'd100, 10'd500, 10'd300, 10'd200, 10'd100};
    localparam logic [49:0] Y_RST = {10'd400, 10'd100, 10'd300, 10'd150, 10'd100};

    logic            commit;
    logic            wr;
    logic [4:0][9:0] sh_x;
    logic [4:0][9:0] sh_y;
    logic [7:0]      sh_sx;
    logic [7:0]      sh_sy;
    logic [11:0]     ld_val;
    logic            ld_pend;
    logic            run;
    logic            clr;
    logic [AW-1:0]   anim_cnt;
    logic [SW-1:0]   score_cnt;
    logic            anim_wrap;
    logic            score_tick;
    logic            unused;

    assign commit      = !reset && vcount == 10'(VACTIVE) && hcount == 11'd0;
    assign wr          = chipselect && write;
    assign frame_start = commit;
    assign anim_wrap   = anim_cnt == AW'(ANIM_DIV - 1);
    assign score_tick  = score_cnt == SW'(SCORE_DIV - 1);
    assign unused      = ^writedata[31:12];

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] o, t, h;
        o = v[3:0];
        t = v[7:4];
        h = v[11:8];
        if (o != 4'd9) begin
            o = o + 4'd1;
        end else begin
            o = 4'd0;
            if (t != 4'd9) begin
                t = t + 4'd1;
            end else begin
                t = 4'd0;
                h = (h == 4'd9) ? 4'd0 : h + 4'd1;
            end
        end
        return {h, t, o};
    endfunction

    // Shadow side: a write landing on the commit cycle wins over the flag drop
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x    <= X_RST;
            sh_y    <= Y_RST;
            sh_sx   <= 8'd25;
            sh_sy   <= 8'd41;
            ld_val  <= 12'd0;
            ld_pend <= 1'b0;
            run     <= 1'b0;
            clr     <= 1'b0;
        end else begin
            if (commit) begin
                ld_pend <= 1'b0;
                clr     <= 1'b0;
            end
            if (wr && address < 9'd10) begin
                if (address[0]) sh_y[address[3:1]] <= writedata[9:0];
                else            sh_x[address[3:1]] <= writedata[9:0];
            end else if (wr) begin
                case (address)
                    9'd10: begin
                        ld_val  <= {clamp9(writedata[11:8]), clamp9(writedata[7:4]),
                                    clamp9(writedata[3:0])};
                        ld_pend <= 1'b1;
                    end
                    9'd11: begin
                        run <= writedata[0];
                        clr <= writedata[1];
                    end
                    9'd12:   sh_sx <= writedata[7:0];
                    9'd13:   sh_sy <= writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spr_x      <= X_RST;
            spr_y      <= Y_RST;
            score_x    <= 8'd25;
            score_y    <= 8'd41;
            score_bcd  <= 12'd0;
            anim_phase <= 2'd0;
            anim_cnt   <= '0;
            score_cnt  <= '0;
        end else if (commit) begin
            spr_x     <= sh_x;
            spr_y     <= sh_y;
            score_x   <= sh_sx;
            score_y   <= sh_sy;
            anim_cnt  <= anim_wrap ? '0 : anim_cnt + 1'b1;
            score_cnt <= score_tick ? '0 : score_cnt + 1'b1;
            if (anim_wrap) anim_phase <= anim_phase + 2'd1;
            if (clr)                     score_bcd <= 12'd0;
            else if (ld_pend)            score_bcd <= ld_val;
            else if (run && score_tick)  score_bcd <= bcd_inc(score_bcd);
        end
    end

`ifdef VGA_FRAME_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset)                          frame_irq <= 1'b0;
        else if (commit)                    frame_irq <= 1'b1;
        else if (wr && address == 9'd15)    frame_irq <= 1'b0;
    end
`else
    assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_regs.sv
// Directed bench: one DUT with default dividers, one with SCORE_DIV=1, driven by hand-placed commit cycles.
`timescale 1ns/1ps
module tb_vga_frame_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    logic [49:0] x, y, x1, y1;
    logic [7:0]  sx, sy, sx1, sy1;
    logic [11:0] bcd, bcd1;
    logic [1:0]  ph, ph1;
    logic        fs, fs1, irq, irq1;

    int tests = 0;
    int fails = 0;

`ifdef VGA_FRAME_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic [49:0] xr = {10'd100, 10'd500, 10'd300, 10'd200, 10'd100};
    logic [49:0] yr = {10'd400, 10'd100, 10'd300, 10'd150, 10'd100};

    vga_frame_regs dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
        .spr_x(x), .spr_y(y), .score_x(sx), .score_y(sy), .score_bcd(bcd),
        .anim_phase(ph), .frame_start(fs), .frame_irq(irq)
    );

    vga_frame_regs #(.SCORE_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
        .spr_x(x1), .spr_y(y1), .score_x(sx1), .score_y(sy1), .score_bcd(bcd1),
        .anim_phase(ph1), .frame_start(fs1), .frame_irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [8:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic commit_frame();
        vcount = 10'd480;
        hcount = 11'd0;
        #1;
        chk("frame_start_on_commit", {49'd0, fs}, 50'd1);
        cyc();
        vcount = 10'd100;
        hcount = 11'd7;
        #1;
        chk("frame_start_pulse_end", {49'd0, fs}, 50'd0);
        chk("irq_after_commit", {49'd0, irq}, {49'd0, IRQ_ON});
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        vcount = 10'd480; hcount = 11'd0;
        cyc();
        cyc();
        chk("no_commit_in_reset", {49'd0, fs}, 50'd0);
        chk("rst_spr_x", x, xr);
        chk("rst_spr_y", y, yr);
        chk("rst_score_x", {42'd0, sx}, 50'd25);
        chk("rst_score_y", {42'd0, sy}, 50'd41);
        chk("rst_bcd", {38'd0, bcd}, 50'd0);
        chk("rst_phase", {48'd0, ph}, 50'd0);
        chk("rst_irq", {49'd0, irq}, 50'd0);
        vcount = 10'd0;
        reset  = 1'b0;
        cyc();
        vcount = 10'd479;
        #1 chk("no_commit_v479", {49'd0, fs}, 50'd0);
        vcount = 10'd480; hcount = 11'd1;
        #1 chk("no_commit_h1", {49'd0, fs}, 50'd0);
        commit_frame();                                   // c1
        chk("c1_spr_x_idle", x, xr);

        vcount = 10'd100;
        wr_reg(9'd0, 32'h123);
        chk("shadow_not_visible", x, xr);
        commit_frame();                                   // c2
        chk("c2_spr_x", x, {10'd100, 10'd500, 10'd300, 10'd200, 10'h123});

        vcount = 10'd480; hcount = 11'd0;
        chipselect = 1'b1; write = 1'b1; address = 9'd1; writedata = 32'd77;
        #1 chk("fs_with_write", {49'd0, fs}, 50'd1);
        cyc();                                            // c3
        chipselect = 1'b0; write = 1'b0;
        vcount = 10'd100; hcount = 11'd7;
        chk("write_on_commit_deferred", y, yr);
        wr_reg(9'd12, 32'h55);
        wr_reg(9'd13, 32'hAA);
        wr_reg(9'd9, 32'h3FF);
        wr_reg(9'd14, 32'h5);
        write = 1'b1; address = 9'd0; writedata = 32'd0;
        cyc();
        write = 1'b0;
        commit_frame();                                   // c4
        chk("c4_spr_y", y, {10'h3FF, 10'd100, 10'd300, 10'd150, 10'd77});
        chk("c4_spr_x_nocs", x, {10'd100, 10'd500, 10'd300, 10'd200, 10'h123});
        chk("c4_score_x", {42'd0, sx}, 50'h55);
        chk("c4_score_y", {42'd0, sy}, 50'hAA);

        wr_reg(9'd10, 32'h998);
        wr_reg(9'd11, 32'h1);
        commit_frame();                                   // c5
        chk("c5_bcd1_load", {38'd0, bcd1}, 50'h998);
        chk("c5_bcd_load", {38'd0, bcd}, 50'h998);
        chk("c5_phase", {48'd0, ph}, 50'd0);
        commit_frame();                                   // c6
        chk("c6_bcd1", {38'd0, bcd1}, 50'h999);
        chk("c6_bcd_no_tick", {38'd0, bcd}, 50'h998);
        chk("c6_phase", {48'd0, ph}, 50'd1);
        commit_frame();                                   // c7
        chk("c7_bcd1_wrap", {38'd0, bcd1}, 50'h000);
        commit_frame();                                   // c8
        chk("c8_bcd1", {38'd0, bcd1}, 50'h001);
        chk("c8_bcd_tick", {38'd0, bcd}, 50'h999);

        wr_reg(9'd10, 32'hA5F);
        commit_frame();                                   // c9
        chk("c9_clamp", {38'd0, bcd}, 50'h959);
        chk("c9_clamp1", {38'd0, bcd1}, 50'h959);
        wr_reg(9'd11, 32'h3);
        wr_reg(9'd10, 32'h123);
        commit_frame();                                   // c10
        chk("c10_clear_wins", {38'd0, bcd}, 50'h000);
        chk("c10_clear_wins1", {38'd0, bcd1}, 50'h000);
        commit_frame();                                   // c11
        chk("c11_bcd1_run", {38'd0, bcd1}, 50'h001);
        chk("c11_bcd", {38'd0, bcd}, 50'h000);
        chk("c11_phase", {48'd0, ph}, 50'd1);
        commit_frame();                                   // c12
        chk("c12_bcd1", {38'd0, bcd1}, 50'h002);
        chk("c12_bcd", {38'd0, bcd}, 50'h001);
        chk("c12_phase", {48'd0, ph}, 50'd2);
        for (int i = 13; i <= 18; i++) commit_frame();
        chk("c18_phase", {48'd0, ph}, 50'd3);
        for (int i = 19; i <= 24; i++) commit_frame();
        chk("c24_phase_wrap", {48'd0, ph}, 50'd0);
        for (int i = 25; i <= 27; i++) commit_frame();

        vcount = 10'd200;
        reset  = 1'b1;
        cyc();
        cyc();
        reset  = 1'b0;
        chk("mid_rst_spr_x", x, xr);
        chk("mid_rst_spr_y", y, yr);
        chk("mid_rst_bcd", {38'd0, bcd1}, 50'd0);
        chk("mid_rst_score_x", {42'd0, sx}, 50'd25);
        chk("mid_rst_irq", {49'd0, irq}, 50'd0);
        commit_frame();
        chk("r1_shadow_x", x, xr);
        chk("r1_shadow_sy", {42'd0, sy}, 50'd41);
        chk("r1_run_off", {38'd0, bcd1}, 50'd0);
        for (int i = 2; i <= 5; i++) commit_frame();
        chk("r5_phase", {48'd0, ph}, 50'd0);
        commit_frame();
        chk("r6_phase", {48'd0, ph}, 50'd1);

        wr_reg(9'd15, 32'h0);
        chk("irq_after_ack", {49'd0, irq}, 50'd0);
        vcount = 10'd480; hcount = 11'd0;
        chipselect = 1'b1; write = 1'b1; address = 9'd15;
        cyc();
        chipselect = 1'b0; write = 1'b0;
        vcount = 10'd100; hcount = 11'd7;
        chk("irq_ack_on_commit", {49'd0, irq}, {49'd0, IRQ_ON});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
